gpio_target: RTL and testbench
==============================

# gpio_target

Memory-mapped bus responder exposing a small register bank: an 8-bit LED output register, a synchronised 8-bit switch input, a 16-bit edge-event counter with control, and a scratch register. Sits on a target port of the shared bus, alongside the plain and split targets, and implements the target side of the initiator/target handshake with a configurable number of wait states.

## Interface
- WAIT_STATES, 1, idle cycles between command capture and response (0..15)
- INTERNAL_ADDR_BITS, 3, low address bits decoded; higher bits ignored (the bus has already range-checked)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- target_addr_in  in  16  transaction address
- target_addr_in_valid  in  1  address/command strobe, one cycle
- target_data_in  in  8  write data
- target_data_in_valid  in  1  write data strobe, one cycle
- target_rw  in  1  1 = write, 0 = read; sampled with target_addr_in_valid
- target_data_out  out  8  read data
- target_data_out_valid  out  1  read data strobe, one cycle
- target_ack  out  1  transaction complete, one cycle
- target_ready  out  1  idle, able to accept a command
- sw_in  in  8  asynchronous switch inputs
- evt_in  in  1  asynchronous event input
- leds  out  8  LED_OUT register value

## Operation
- Register map (offset = addr[2:0]):
  - 0 LED_OUT, RW
  - 1 SW_IN, RO (synchronised)
  - 2 CNT_LO, RO; a read also latches CNT[15:8] into CNT_HI_SHADOW
  - 3 CNT_HI, RO; returns the shadow
  - 4 CTRL, RW; bit0 = count enable, bit1 = clear (self-clearing, always reads 0), bits 7:2 read 0
  - 5 SCRATCH, RW
  - 6, 7 read 0x00; writes are ignored but still acked
- Writes to RO registers: ignored, acked.
- FSM states:
  - IDLE: ready = 1. On addr_valid, capture addr and rw.
    - Read -> WAIT.
    - Write with data_in_valid in the same cycle -> capture data -> WAIT.
    - Write without data -> WDATA.
  - WDATA: wait for data_in_valid, capture data -> WAIT.
  - WAIT: count WAIT_STATES cycles -> RESP. With WAIT_STATES = 0, WAIT is skipped and the FSM goes straight to RESP.
  - RESP: one cycle.
    - target_ack = 1.
    - Reads: data_out_valid = 1 and data_out = register value.
    - Writes: the register updates on this edge.
    - Then -> IDLE.
- addr_valid while ready = 0: ignored. data_in_valid outside IDLE/WDATA: ignored.
- Counter:
  - Increments by 1 on each synchronised rising edge of evt_in while CTRL.bit0 = 1.
  - Wraps 0xFFFF -> 0x0000.
  - Clear and increment in the same cycle: clear wins, result is 0.
- sw_in and evt_in each pass through two flip-flops. Edge detection uses a third flop.

## Timing
- Reset values: ready = 1, ack = 0, data_out_valid = 0, data_out = 0x00, leds = 0x00, CTRL = 0, SCRATCH = 0, CNT = 0, shadow = 0, FSM = IDLE.
- data_out holds its last read value between reads.
- Read: addr_valid at cycle 0 -> ack and data_out_valid at cycle WAIT_STATES+1.
- Write: data captured at cycle d -> ack at cycle d+WAIT_STATES+1; leds reflect the write one cycle after ack.
- ready falls the cycle after capture and rises the cycle after RESP, so the minimum command spacing is WAIT_STATES+2 cycles.
- SW_IN read latency: sw_in change is visible after 2 clk edges plus the transaction latency.
- Counter update: 3 cycles after an evt_in rising edge.
- Reset mid-transaction: all state returns to reset values immediately. No ack is produced for the aborted transaction.

## Structure
- gpio_target_pkg holds:
  - register offset localparams
  - CTRL bit indices
  - the state enum typedef (IDLE, WDATA, WAIT, RESP)
- One sub-module, gpio_event_counter, contains:
  - the evt_in synchroniser and edge detector
  - the 16-bit enable/clear/wrap counter
  - the read-triggered high-byte shadow latch

## Test plan
- Write 0xA5 to offset 0 (data in the same cycle as the address, WAIT_STATES = 1) -> ack at cycle 2; leds = 0xA5 one cycle later. Read offset 0 -> data_out 0xA5 with data_out_valid at cycle 2.
- Write to offset 5 with data_in_valid 3 cycles after the address -> ready stays low throughout; ack at cycle 5. Read back 0x3C. A second addr_valid issued during the transaction is ignored.
- Hold sw_in = 0x81 -> read offset 1 returns 0x81. Write 0xFF to offset 1 -> acked; a subsequent read still returns 0x81.
- CTRL = 0x01, then 300 evt_in pulses. Read CNT_LO = 0x2C, then change evt_in, then read CNT_HI = 0x01 (shadowed value). Preset the count to 0xFFFF, one more pulse -> reads 0x0000.
- Write CTRL = 0x03 coincident with an event edge -> counter = 0; a CTRL readback returns 0x01.
- Assert rst while in WAIT -> ready = 1 and no ack. A read of offset 7 after reset returns 0x00 with ack. Repeat with WAIT_STATES = 0 -> read ack at cycle 1.

Source files
------------

// File: rtl/gpio_target_pkg.sv
// Shared definitions for the GPIO bus target: register offsets, CTRL bits, FSM states.
package gpio_target_pkg;
  localparam logic [2:0] OFF_LED     = 3'd0;
  localparam logic [2:0] OFF_SW      = 3'd1;
  localparam logic [2:0] OFF_CNT_LO  = 3'd2;
  localparam logic [2:0] OFF_CNT_HI  = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_e;
endpackage

// File: rtl/gpio_event_counter.sv
// evt_in synchroniser + rising-edge detector feeding a 16-bit counter with a
// high-byte shadow latched whenever the low byte is read.
module gpio_event_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        evt_in,
  input  logic        en,
  input  logic        clr,
  input  logic        lo_rd,
  output logic [15:0] cnt,
  output logic [7:0]  cnt_hi_shadow
);
  logic [2:0]  evt_sr;
  logic [15:0] cnt_q;
  logic [7:0]  shadow_q;
  logic        evt_rise;

  // evt_sr[1:0] is the two-flop synchroniser, evt_sr[2] the edge-detect history
  assign evt_rise = evt_sr[1] & ~evt_sr[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_sr   <= '0;
      shadow_q <= '0;
    end else begin
      evt_sr <= {evt_sr[1:0], evt_in};
      if (lo_rd) shadow_q <= cnt_q[15:8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (clr)            cnt_q <= '0;
    else if (en && evt_rise) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt           = cnt_q;
  assign cnt_hi_shadow = shadow_q;
endmodule

// File: rtl/gpio_target.sv
// GPIO register bank on a shared-bus target port: LEDs, synchronised switches,
// event counter, scratch; responds after a fixed number of wait states.
module gpio_target
  import gpio_target_pkg::*;
#(
  parameter int WAIT_STATES        = 1,
  parameter int INTERNAL_ADDR_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target_addr_in,
  input  logic        target_addr_in_valid,
  input  logic [7:0]  target_data_in,
  input  logic        target_data_in_valid,
  input  logic        target_rw,
  output logic [7:0]  target_data_out,
  output logic        target_data_out_valid,
  output logic        target_ack,
  output logic        target_ready,
  input  logic [7:0]  sw_in,
  input  logic        evt_in,
  output logic [7:0]  leds
);
  localparam int AW = INTERNAL_ADDR_BITS;
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam state_e AFTER_CAP = (WAIT_STATES == 0) ? RESP : WAIT;

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [7:0]    wdata_q, leds_q, scratch_q, dout_q, rd_data;
  logic          ctrl_en_q;
  logic [7:0]    sw_s1, sw_s2;
  logic [15:0]   cnt;
  logic [7:0]    cnt_hi_shadow;
  logic          cap_cmd, cap_data, resp_wr, resp_rd, cnt_clr, cnt_lo_rd;
  logic          addr_hi_unused;

  // upper address bits were range-checked by the bus fabric
  assign addr_hi_unused = ^target_addr_in[15:AW];

  assign cap_cmd  = (state_q == IDLE) && target_addr_in_valid;
  assign cap_data = (cap_cmd && target_rw && target_data_in_valid) ||
                    ((state_q == WDATA) && target_data_in_valid);
  assign resp_wr  = (state_q == RESP) && rw_q;
  assign resp_rd  = (state_q == RESP) && !rw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (target_addr_in_valid) begin
               if (!target_rw || target_data_in_valid) state_d = AFTER_CAP;
               else                                    state_d = WDATA;
             end
      WDATA: if (target_data_in_valid) state_d = AFTER_CAP;
      WAIT:  if (wcnt_q == WS_LAST) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target_ready          = (state_q == IDLE);
    target_ack            = (state_q == RESP);
    target_data_out_valid = resp_rd;
    target_data_out       = resp_rd ? rd_data : dout_q;
  end

  always_comb begin
    rd_data = '0;
    case (addr_q)
      AW'(OFF_LED):     rd_data = leds_q;
      AW'(OFF_SW):      rd_data = sw_s2;
      AW'(OFF_CNT_LO):  rd_data = cnt[7:0];
      AW'(OFF_CNT_HI):  rd_data = cnt_hi_shadow;
      AW'(OFF_CTRL):    rd_data = {7'd0, ctrl_en_q};
      AW'(OFF_SCRATCH): rd_data = scratch_q;
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      leds_q    <= '0;
      scratch_q <= '0;
      ctrl_en_q <= 1'b0;
      dout_q    <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      wcnt_q <= (state_q == WAIT) ? wcnt_q + 4'd1 : 4'd0;
      if (cap_cmd) begin
        addr_q <= target_addr_in[AW-1:0];
        rw_q   <= target_rw;
      end
      if (cap_data) wdata_q <= target_data_in;
      if (resp_rd)  dout_q  <= rd_data;
      if (resp_wr) begin
        case (addr_q)
          AW'(OFF_LED):     leds_q    <= wdata_q;
          AW'(OFF_CTRL):    ctrl_en_q <= wdata_q[CTRL_EN_BIT];
          AW'(OFF_SCRATCH): scratch_q <= wdata_q;
          default: ;
        endcase
      end
    end
  end

  // clear is a write-side strobe only; it never lands in a register
  assign cnt_clr   = resp_wr && (addr_q == AW'(OFF_CTRL)) && wdata_q[CTRL_CLR_BIT];
  assign cnt_lo_rd = resp_rd && (addr_q == AW'(OFF_CNT_LO));

  gpio_event_counter u_evt (
    .clk           (clk),
    .rst           (rst),
    .evt_in        (evt_in),
    .en            (ctrl_en_q),
    .clr           (cnt_clr),
    .lo_rd         (cnt_lo_rd),
    .cnt           (cnt),
    .cnt_hi_shadow (cnt_hi_shadow)
  );

  assign leds = leds_q;
endmodule

// File: tb/tb_gpio_target.sv
// Directed + randomized bench for gpio_target against a register-level model.
module tb_gpio_target;
  localparam int WS = 1;

  logic        clk = 0;
  logic        rst;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid, target_data_in_valid, target_rw, evt_in;
  logic [7:0]  target_data_in, sw_in;
  logic [7:0]  target_data_out, leds, data_out0, leds0;
  logic        target_data_out_valid, target_ack, target_ready;
  logic        dov0, ack0, ready0;

  gpio_target #(.WAIT_STATES(WS), .INTERNAL_ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
    .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
    .target_rw(target_rw), .target_data_out(target_data_out),
    .target_data_out_valid(target_data_out_valid), .target_ack(target_ack),
    .target_ready(target_ready), .sw_in(sw_in), .evt_in(evt_in), .leds(leds));

  gpio_target #(.WAIT_STATES(0), .INTERNAL_ADDR_BITS(3)) dut0 (
    .clk(clk), .rst(rst),
    .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
    .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
    .target_rw(target_rw), .target_data_out(data_out0),
    .target_data_out_valid(dov0), .target_ack(ack0),
    .target_ready(ready0), .sw_in(sw_in), .evt_in(evt_in), .leds(leds0));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // register-level reference model
  logic [7:0]  leds_m = 0, scratch_m = 0, sw_m = 0, shadow_m = 0, last_rd = 0;
  logic        en_m = 0;
  logic [15:0] cnt_m = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] off);
    logic [7:0] v;
    case (off)
      3'd0: v = leds_m;
      3'd1: v = sw_m;
      3'd2: begin v = cnt_m[7:0]; shadow_m = cnt_m[15:8]; end
      3'd3: v = shadow_m;
      3'd4: v = {7'd0, en_m};
      3'd5: v = scratch_m;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [2:0] off, input logic [7:0] d);
    case (off)
      3'd0: leds_m = d;
      3'd4: begin en_m = d[0]; if (d[1]) cnt_m = 16'h0000; end
      3'd5: scratch_m = d;
      default: ;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      @(posedge clk); #1 evt_in = 1;
      @(posedge clk); @(posedge clk); #1 evt_in = 0;
      @(posedge clk); #1;
      if (en_m) cnt_m = cnt_m + 16'd1;
    end
    idle(4);
  endtask

  // One bus transaction. dly = cycles from address to write data; spur = cycle
  // at which an extra (must-be-ignored) command is driven, 0 = none.
  task automatic xact(input logic [2:0] off, input bit wr, input logic [7:0] wd,
                      input int dly, input int spur, input bit evt_now);
    logic [15:0] a, a2;
    logic [7:0]  exp_rd, rd;
    logic        dovv;
    int          lat, exp_lat;
    bit          rdy_bad;
    a = 16'($urandom); a[2:0] = off;
    a2 = 16'($urandom); a2[2:0] = 3'd0;
    exp_rd = wr ? 8'h00 : m_read(off);
    exp_lat = wr ? dly + WS + 1 : WS + 1;
    rd = 0; dovv = 0; lat = -1; rdy_bad = 0;
    @(posedge clk); #1;
    target_addr_in = a; target_rw = wr; target_addr_in_valid = 1;
    if (evt_now) evt_in = 1;
    if (wr && dly == 0) begin target_data_in = wd; target_data_in_valid = 1; end
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c > 0 && target_ready) rdy_bad = 1;
      if (target_ack) begin
        lat = c; rd = target_data_out; dovv = target_data_out_valid;
      end else begin
        @(posedge clk); #1;
        target_addr_in_valid = 0; target_data_in_valid = 0;
        if (spur != 0 && c + 1 == spur) begin
          target_addr_in = a2; target_rw = 1; target_addr_in_valid = 1;
        end
        if (wr && dly > 0 && c + 1 == dly) begin
          target_data_in = wd; target_data_in_valid = 1;
        end
      end
    end
    if (wr) m_write(off, wd);
    chk("latency", 16'(lat), 16'(exp_lat));
    chk("ready_low", 16'(rdy_bad), 16'd0);
    if (wr) chk("wr_dov", 16'(dovv), 16'd0);
    else begin
      chk("rd_dov", 16'(dovv), 16'd1);
      chk("rd_data", 16'(rd), 16'(exp_rd));
      last_rd = exp_rd;
    end
    @(posedge clk); #1;
    target_addr_in_valid = 0; target_data_in_valid = 0;
    @(negedge clk);
    chk("ready_back", 16'(target_ready), 16'd1);
    chk("leds", 16'(leds), 16'(leds_m));
  endtask

  initial begin
    int          lat, lat0;
    logic [7:0]  d, d0;
    bit          saw_ack;
    logic [15:0] a;
    rst = 1; target_addr_in = 0; target_addr_in_valid = 0; target_data_in = 0;
    target_data_in_valid = 0; target_rw = 0; sw_in = 0; evt_in = 0;
    idle(3);
    @(negedge clk);
    chk("rst_ready", 16'(target_ready), 16'd1);
    chk("rst_ack", 16'(target_ack), 16'd0);
    chk("rst_dov", 16'(target_data_out_valid), 16'd0);
    chk("rst_dout", 16'(target_data_out), 16'h00);
    chk("rst_leds", 16'(leds), 16'h00);
    @(posedge clk); #1 rst = 0;
    idle(2);

    // LED write with data alongside address, then readback
    xact(3'd0, 1, 8'hA5, 0, 0, 0);
    xact(3'd0, 0, 8'h00, 0, 0, 0);
    // late write data with a stray command in flight
    xact(3'd5, 1, 8'h3C, 3, 1, 0);
    xact(3'd5, 0, 8'h00, 0, 0, 0);

    // switches and read-only write
    sw_in = 8'h81; sw_m = 8'h81; idle(3);
    xact(3'd1, 0, 8'h00, 0, 0, 0);
    xact(3'd1, 1, 8'hFF, 0, 0, 0);
    xact(3'd1, 0, 8'h00, 0, 0, 0);

    // event counter and high-byte shadow
    xact(3'd4, 1, 8'h01, 0, 0, 0);
    pulse(300);
    xact(3'd2, 0, 8'h00, 0, 0, 0);
    chk("cnt_lo_300", 16'(last_rd), 16'h2C);
    pulse(5);
    xact(3'd3, 0, 8'h00, 0, 0, 0);
    chk("cnt_hi_shadow", 16'(last_rd), 16'h01);
    xact(3'd2, 0, 8'h00, 0, 0, 0);

    // wrap from 0xFFFF
    force dut.u_evt.cnt_q = 16'hFFFF;
    idle(1);
    release dut.u_evt.cnt_q;
    cnt_m = 16'hFFFF;
    pulse(1);
    xact(3'd2, 0, 8'h00, 0, 0, 0);
    xact(3'd3, 0, 8'h00, 0, 0, 0);
    chk("wrap_hi", 16'(last_rd), 16'h00);

    // clear coincident with an event edge: clear wins
    pulse(3);
    xact(3'd4, 1, 8'h03, 0, 0, 1);
    idle(3); evt_in = 0; idle(4);
    xact(3'd4, 0, 8'h00, 0, 0, 0);
    xact(3'd2, 0, 8'h00, 0, 0, 0);
    chk("clr_wins", 16'(last_rd), 16'h00);

    // randomized traffic against the model
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw_in = 8'($urandom); sw_m = sw_in; idle(1);
      end
      xact(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 3), 0, 0);
    end

    // read data holds between reads
    xact(3'd5, 0, 8'h00, 0, 0, 0);
    idle(3);
    @(negedge clk);
    chk("dout_hold", 16'(target_data_out), 16'(last_rd));

    // reset while waiting: no ack for the aborted read
    @(posedge clk); #1;
    target_addr_in = 16'h0005; target_rw = 0; target_addr_in_valid = 1;
    @(posedge clk); #1;
    target_addr_in_valid = 0;
    rst = 1; #1;
    chk("midrst_ready", 16'(target_ready), 16'd1);
    chk("midrst_ack", 16'(target_ack), 16'd0);
    @(posedge clk); #1 rst = 0;
    leds_m = 0; scratch_m = 0; en_m = 0; cnt_m = 0; shadow_m = 0;
    saw_ack = 0;
    repeat (4) begin @(negedge clk); if (target_ack) saw_ack = 1; end
    chk("no_ack_after_rst", 16'(saw_ack), 16'd0);
    chk("leds_after_rst", 16'(leds), 16'h00);

    // offset 7 read on both wait-state configurations
    a = 16'($urandom); a[2:0] = 3'd7;
    @(posedge clk); #1;
    target_addr_in = a; target_rw = 0; target_addr_in_valid = 1;
    lat = -1; lat0 = -1; d = 8'hEE; d0 = 8'hEE;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack0 && lat0 < 0) begin lat0 = c; d0 = data_out0; end
      if (target_ack && lat < 0) begin lat = c; d = target_data_out; end
      @(posedge clk); #1 target_addr_in_valid = 0;
    end
    chk("off7_lat_ws1", 16'(lat), 16'd2);
    chk("off7_data_ws1", 16'(d), 16'h00);
    chk("off7_lat_ws0", 16'(lat0), 16'd1);
    chk("off7_data_ws0", 16'(d0), 16'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
